dot_acc: RTL



---
 rtl/dot_acc.sv | 88 ++++++++
 1 files changed

// File: rtl/dot_acc.sv
// Dot-product accumulator: pops VEC_LEN unsigned 16-bit products from an upstream FIFO,
// sums them and offers the result on a SUM_VALID/SUM_READY handshake.
module dot_acc #(
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EMPTY,
    input  logic             VALID,
    input  logic [15:0]      DIN,
    output logic             RD,
    output logic [ACC_W-1:0] SUM,
    output logic             SUM_VALID,
    input  logic             SUM_READY,
    output logic             OVF,
    output logic             BUSY
);
    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(VEC_LEN - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] recv;
    logic             ovf_acc;
    logic [ACC_W:0]   add_p0;

    // Unsigned add of a zero-extended product; bit ACC_W is the carry out.
    function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] a,
                                                 input logic [15:0]      b);
        return {1'b0, a} + {{(ACC_W - 15){1'b0}}, b};
    endfunction

    assign add_p0 = add_carry(acc, DIN);

    // Reads are capped at VEC_LEN per vector and stop entirely while a result is held.
    assign RD   = !RST && (state == ACCUM) && !EMPTY && (issued < LEN_C);
    assign BUSY = (state == ACCUM) && (issued != '0);

    // Stage p0 -> p1: accumulate beats, then hold the finished sum until accepted
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ACCUM;
            acc       <= '0;
            SUM       <= '0;
            issued    <= '0;
            recv      <= '0;
            ovf_acc   <= 1'b0;
            SUM_VALID <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (RD) begin
                        issued <= issued + 1'b1;
                    end
                    if (VALID) begin
                        acc     <= add_p0[ACC_W-1:0];
                        ovf_acc <= ovf_acc | add_p0[ACC_W];
                        recv    <= recv + 1'b1;
                        if (recv == LAST_C) begin
                            SUM       <= add_p0[ACC_W-1:0];
                            OVF       <= ovf_acc | add_p0[ACC_W];
                            SUM_VALID <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // SUM and OVF deliberately keep the accepted result until the next one.
                    if (SUM_READY) begin
                        SUM_VALID <= 1'b0;
                        acc       <= '0;
                        issued    <= '0;
                        recv      <= '0;
                        ovf_acc   <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule
